// File: rtl/systolic_feed_ctrl_if.sv
// Host/buffer-side bundle of the systolic feed sequencer: job handshake,
// operand buffer read port, skewed array edge operands and perf counter.
interface systolic_feed_ctrl_if #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int AW = 8
);
  logic                 start;
  logic [AW:0]          k_len;
  logic                 busy;
  logic                 done;
  logic                 arr_clr;
  logic                 rd_en;
  logic [AW-1:0]        rd_addr;
  logic [N-1:0][DW-1:0] a_rdata;
  logic [N-1:0][DW-1:0] b_rdata;
  logic [N-1:0][DW-1:0] a_edge;
  logic [N-1:0][DW-1:0] b_edge;
  logic [31:0]          perf_cycles;

  // host / buffer / array side
  modport master (
    output start, k_len, a_rdata, b_rdata,
    input  busy, done, arr_clr, rd_en, rd_addr, a_edge, b_edge, perf_cycles
  );

  // sequencer side
  modport slave (
    input  start, k_len, a_rdata, b_rdata,
    output busy, done, arr_clr, rd_en, rd_addr, a_edge, b_edge, perf_cycles
  );
endinterface

// File: rtl/systolic_feed_ctrl.sv
// Feed sequencer for an N x N output-stationary systolic MAC array.
// Clears the accumulators, streams K reduction steps out of the A/B operand
// buffers, applies the triangular edge skew, waits out the array drain and
// pulses done when results are final.
// Optional busy-cycle counter: define SYSTOLIC_FEED_PERF_EN.

// One array edge lane: LANE+1 registers (capture + LANE skew stages, the last
// one being the edge output). Each stage is gated by the valid tag that
// travels alongside it, so bubbles reach the array as zeros.
module systolic_feed_lane #(
  parameter int LANE = 0,
  parameter int DW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [LANE:0] vld,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out
);
  logic [LANE:0][DW-1:0] sa, sb;

  // capture stage followed by the per-lane skew shift, zero when untagged
  always_ff @(posedge clk) begin
    if (rst) begin
      sa <= '0;
      sb <= '0;
    end else begin
      sa[0] <= vld[0] ? a_in : '0;
      sb[0] <= vld[0] ? b_in : '0;
      for (int j = 1; j <= LANE; j++) begin
        sa[j] <= vld[j] ? sa[j-1] : '0;
        sb[j] <= vld[j] ? sb[j-1] : '0;
      end
    end
  end

  assign a_out = sa[LANE];
  assign b_out = sb[LANE];
endmodule

module systolic_feed_ctrl #(
  parameter int N       = 4,
  parameter int DW      = 8,
  parameter int AW      = 8,
  parameter int MUL_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  systolic_feed_ctrl_if.slave bus
);
  // operands cross the array diagonally (2*(N-1)), then the multiplier
  // pipe and the accumulate/settle stages must empty
  localparam int DRAIN_CYC = 2*(N-1) + MUL_LAT + 2;
  localparam int DCW       = $clog2(DRAIN_CYC + 1);
  localparam int STAGES    = N - 1;

  localparam logic [DCW-1:0] DRAIN_LD = DCW'(DRAIN_CYC - 1);
  localparam logic [DCW-1:0] ONE_D    = DCW'(1);
  localparam logic [AW-1:0]  ONE_A    = AW'(1);
  localparam logic [AW:0]    ONE_K    = (AW+1)'(1);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

  state_t              state;
  logic                busy, done, arr_clr, rd_en;
  logic [AW-1:0]       rd_addr;
  logic [AW:0]         k_lat;
  logic [AW:0]         k_m1;
  logic [DCW-1:0]      drain_cnt;
  logic [STAGES:0]     vld_pipe;
  logic [N-1:0][DW-1:0] a_edge_w, b_edge_w;

  // last address to issue; only consulted in FEED, where K >= 1
  assign k_m1 = k_lat - ONE_K;

  // job sequencer; every output is a register updated with the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      arr_clr   <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      k_lat     <= '0;
      drain_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            k_lat   <= bus.k_len;
            state   <= CLEAR;
            busy    <= 1'b1;
            arr_clr <= 1'b1;
          end
        end
        CLEAR: begin
          arr_clr <= 1'b0;
          rd_addr <= '0;
          if (k_lat != '0) begin
            state <= FEED;
            rd_en <= 1'b1;
          end else begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_LD;
          end
        end
        FEED: begin
          // at K = 2^AW the final increment wraps to 0 with rd_en already low
          rd_addr <= rd_addr + ONE_A;
          if ({1'b0, rd_addr} == k_m1) begin
            rd_en     <= 1'b0;
            state     <= DRAIN;
            drain_cnt <= DRAIN_LD;
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - ONE_D;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // valid tag: bit 0 marks the cycle buffer data is on a/b_rdata,
  // bit j follows the same element into skew stage j
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= rd_en;
      for (int j = 1; j <= STAGES; j++) vld_pipe[j] <= vld_pipe[j-1];
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    systolic_feed_lane #(.LANE(g), .DW(DW)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .vld   (vld_pipe[g:0]),
      .a_in  (bus.a_rdata[g]),
      .b_in  (bus.b_rdata[g]),
      .a_out (a_edge_w[g]),
      .b_out (b_edge_w[g])
    );
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.arr_clr = arr_clr;
  assign bus.rd_en   = rd_en;
  assign bus.rd_addr = rd_addr;
  assign bus.a_edge  = a_edge_w;
  assign bus.b_edge  = b_edge_w;

`ifdef SYSTOLIC_FEED_PERF_EN
  logic [31:0] perf_cnt, perf_nxt, perf_q;

  assign perf_nxt = (perf_cnt == '1) ? perf_cnt : perf_cnt + 32'd1;

  // busy-cycle counter; the DONE cycle itself is included in the snapshot
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt <= '0;
      perf_q   <= '0;
    end else begin
      if (state == IDLE && bus.start) perf_cnt <= '0;
      else if (busy)                  perf_cnt <= perf_nxt;
      if (state == DONE)              perf_q   <= perf_nxt;
    end
  end

  assign bus.perf_cycles = perf_q;
`else
  assign bus.perf_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Scoreboard bench for systolic_feed_ctrl: per-job expectations (clear,
// addresses, done, busy window) are queued at start, edge operands are queued
// as reads are issued, and everything is checked as the DUT produces it.
module tb_systolic_feed_ctrl;
  localparam int N         = 4;
  localparam int DW        = 8;
  localparam int AW        = 8;
  localparam int MUL_LAT   = 1;
  localparam int DRAIN_CYC = 2*(N-1) + MUL_LAT + 2;
`ifdef SYSTOLIC_FEED_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_feed_ctrl_if #(.N(N), .DW(DW), .AW(AW)) bus  ();
  systolic_feed_ctrl_if #(.N(N), .DW(DW), .AW(3))  bus3 ();

  systolic_feed_ctrl #(.N(N), .DW(DW), .AW(AW), .MUL_LAT(MUL_LAT)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  systolic_feed_ctrl #(.N(N), .DW(DW), .AW(3), .MUL_LAT(MUL_LAT)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  typedef struct { int unsigned due; int unsigned addr; } rd_t;
  typedef struct { int unsigned due; int lane; logic [DW-1:0] a; logic [DW-1:0] b; } edge_t;
  typedef struct { int unsigned lo; int unsigned hi; } win_t;

  rd_t         rd_q[$];
  edge_t       edge_q[$];
  win_t        win_q[$];
  int unsigned clr_q[$];
  int unsigned done_q[$];

  int unsigned   cyc;
  int            n_cmp, n_bad;
  logic          pend;
  logic [AW-1:0] pend_addr;

  function automatic logic [DW-1:0] a_val(input int k, input int i);
    return DW'(16*k + i);
  endfunction

  function automatic logic [DW-1:0] b_val(input int k, input int i);
    return DW'(8'h80 ^ DW'(16*k + i));
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h exp %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void push_job(input int unsigned t0, input int k);
    clr_q.push_back(t0 + 1);
    for (int j = 0; j < k; j++) rd_q.push_back('{t0 + 2 + j, j});
    done_q.push_back(t0 + 2 + k + DRAIN_CYC);
    win_q.push_back('{t0 + 1, t0 + 2 + k + DRAIN_CYC});
  endfunction

  function automatic void flush();
    rd_q.delete(); edge_q.delete(); win_q.delete(); clr_q.delete(); done_q.delete();
    pend = 1'b0;
  endfunction

  // advance one cycle; operand buffers answer a read one cycle later,
  // otherwise they drive junk that must never reach the array
  task automatic step_raw();
    @(posedge clk); #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      bus.a_rdata[i] = pend ? a_val(int'(pend_addr), i) : DW'($urandom);
      bus.b_rdata[i] = pend ? b_val(int'(pend_addr), i) : DW'($urandom);
    end
    pend = 1'b0;
  endtask

  task automatic step();
    logic [N-1:0][DW-1:0] ea, eb;
    logic exp_busy;
    step_raw();
    // accumulator clear
    if (bus.arr_clr) begin
      if (clr_q.size() == 0) chk("clr_extra", bus.arr_clr, 1'b0);
      else chk("clr_cyc", cyc, clr_q.pop_front());
    end else if (clr_q.size() > 0 && clr_q[0] == cyc) begin
      chk("clr_miss", bus.arr_clr, 1'b1);
      void'(clr_q.pop_front());
    end
    // reads and resulting edge operands
    if (bus.rd_en) begin
      pend = 1'b1;
      pend_addr = bus.rd_addr;
      if (rd_q.size() == 0) chk("rd_extra", bus.rd_en, 1'b0);
      else begin
        rd_t r;
        r = rd_q.pop_front();
        chk("rd_cyc", cyc, r.due);
        chk("rd_addr", bus.rd_addr, r.addr);
        for (int i = 0; i < N; i++)
          edge_q.push_back('{cyc + 2 + i, i, a_val(int'(r.addr), i), b_val(int'(r.addr), i)});
      end
    end else if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      chk("rd_miss", bus.rd_en, 1'b1);
      void'(rd_q.pop_front());
    end
    ea = '0;
    eb = '0;
    for (int j = edge_q.size() - 1; j >= 0; j--) begin
      if (edge_q[j].due == cyc) begin
        ea[edge_q[j].lane] = edge_q[j].a;
        eb[edge_q[j].lane] = edge_q[j].b;
        edge_q.delete(j);
      end
    end
    chk("a_edge", bus.a_edge, ea);
    chk("b_edge", bus.b_edge, eb);
    // busy window
    exp_busy = 1'b0;
    foreach (win_q[j]) if (cyc >= win_q[j].lo && cyc <= win_q[j].hi) exp_busy = 1'b1;
    while (win_q.size() > 0 && win_q[0].hi <= cyc) void'(win_q.pop_front());
    chk("busy", bus.busy, exp_busy);
    // completion pulse
    if (bus.done) begin
      if (done_q.size() == 0) chk("done_extra", bus.done, 1'b0);
      else chk("done_cyc", cyc, done_q.pop_front());
    end else if (done_q.size() > 0 && done_q[0] == cyc) begin
      chk("done_miss", bus.done, 1'b1);
      void'(done_q.pop_front());
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},  bus.busy,    1'b0);
    chk({tag, "_done"},  bus.done,    1'b0);
    chk({tag, "_clr"},   bus.arr_clr, 1'b0);
    chk({tag, "_rden"},  bus.rd_en,   1'b0);
    chk({tag, "_addr"},  bus.rd_addr, '0);
    chk({tag, "_aedge"}, bus.a_edge,  '0);
    chk({tag, "_bedge"}, bus.b_edge,  '0);
    chk({tag, "_perf"},  bus.perf_cycles, '0);
  endtask

  task automatic job(input int k);
    int unsigned t0;
    t0 = cyc;
    bus.start = 1'b1;
    bus.k_len = (AW+1)'(k);
    push_job(t0, k);
    step();
    bus.start = 1'b0;
    while (cyc < t0 + 2 + k + DRAIN_CYC + 2) step();
    chk("perf", bus.perf_cycles, PERF ? 32'(1 + k + DRAIN_CYC + 1) : 32'd0);
    chk("sb_left", rd_q.size() + clr_q.size() + done_q.size() + edge_q.size(), 0);
  endtask

  initial begin
    int unsigned t0;
    int unsigned a3[$];
    int unsigned e3;
    int nd3;
    n_cmp = 0; n_bad = 0; cyc = 0; pend = 1'b0;
    rst = 1'b1;
    bus.start = 1'b0;  bus.k_len = '0;  bus.a_rdata = '0;  bus.b_rdata = '0;
    bus3.start = 1'b0; bus3.k_len = '0; bus3.a_rdata = '0; bus3.b_rdata = '0;

    repeat (3) step_raw();
    chk_idle("rst");
    rst = 1'b0;
    repeat (2) step();

    // basic job, then the empty reduction
    job(3);
    job(0);
    job(5);

    // start held high across a whole job: second job only from IDLE
    t0 = cyc;
    bus.start = 1'b1;
    bus.k_len = (AW+1)'(3);
    push_job(t0, 3);
    push_job(t0 + 15, 3);
    while (cyc < t0 + 21) step();
    bus.start = 1'b0;
    while (cyc < t0 + 15 + 14 + 2) step();
    chk("hold_perf", bus.perf_cycles, PERF ? 32'd14 : 32'd0);
    chk("hold_left", rd_q.size() + done_q.size(), 0);

    // reset in the middle of a job
    t0 = cyc;
    bus.start = 1'b1;
    bus.k_len = (AW+1)'(3);
    push_job(t0, 3);
    step();
    bus.start = 1'b0;
    while (cyc < t0 + 5) step();
    rst = 1'b1;
    step_raw();
    flush();
    rst = 1'b0;
    chk_idle("midrst");
    repeat (15) step();
    job(2);

    // full-depth reduction on the AW=3 instance
    t0 = cyc;
    nd3 = 0;
    bus3.start = 1'b1;
    bus3.k_len = 4'd8;
    for (int k = 0; k < 8; k++) a3.push_back(k);
    repeat (30) begin
      step();
      bus3.start = 1'b0;
      if (bus3.rd_en) begin
        if (a3.size() == 0) chk("mk_extra", bus3.rd_en, 1'b0);
        else begin
          e3 = a3.pop_front();
          chk("mk_addr", bus3.rd_addr, e3);
          chk("mk_cyc", cyc, t0 + 2 + e3);
        end
      end
      if (bus3.done) begin
        nd3++;
        chk("mk_done", cyc, t0 + 19);
      end
    end
    chk("mk_left", a3.size(), 0);
    chk("mk_ndone", nd3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
